// File: rtl/axi4_imem_read_slave.sv
// axi4_imem_read_slave
//   AXI4 read-only slave serving instruction-line refills from an on-chip
//   32-bit word memory. FIXED / INCR / WRAP bursts, RREADY back-pressure,
//   and a backdoor write port for preloading.
//
//   Optional build macro: AXI_RD_SLVERR_EN
//     defined   : beats outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH) or with
//                 ARSIZE != 3'b010 return RRESP=SLVERR and RDATA=0.
//     undefined : RRESP is always OKAY and addresses alias modulo MEM_DEPTH.
//
//   Handshake rule (both AR and R channels): a transfer happens on a rising
//   clk edge where VALID and READY are both high; once RVALID is raised,
//   RDATA/RRESP/RLAST/RVALID hold until that transfer occurs.
`timescale 1ns/1ps
module axi4_imem_read_slave #(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    input  logic        mem_we,
    input  logic [31:0] mem_waddr,
    input  logic [31:0] mem_wdata,
    output logic        dbg_burst_o
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;

    logic [31:0] mem_q [MEM_DEPTH];

    logic [31:0] nxt_addr;
    logic        ar_err;
    logic        nxt_err;
    logic        unused_sig;

    // Byte address -> word index, aliasing modulo MEM_DEPTH.
    function automatic logic [AW-1:0] word_idx(input logic [31:0] byte_addr);
        return AW'((byte_addr - BASE_ADDR) >> 2);
    endfunction

    // Address of the following beat. WRAP only wraps for 2/4/8/16-beat
    // bursts; every other length (and the reserved burst code) steps like INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] inc;
        logic [31:0] mask;
        logic [31:0] res;
        inc  = a + 32'd4;
        mask = {22'd0, len, 2'b11};
        res  = inc;
        if (burst == 2'b00) begin
            res = a;
        end else if (burst == 2'b10 &&
                     (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            res = (a & ~mask) | (inc & mask);
        end
        return res;
    endfunction

    assign nxt_addr = next_addr(addr_q, len_q, burst_q);

`ifdef AXI_RD_SLVERR_EN
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);

    function automatic logic out_of_range(input logic [31:0] a);
        return (a - BASE_ADDR) >= MEM_BYTES;
    endfunction

    assign ar_err  = out_of_range(S_AXI_ARADDR) || (S_AXI_ARSIZE != 3'b010);
    assign nxt_err = out_of_range(nxt_addr) || (size_q != 3'b010);
`else
    assign ar_err  = 1'b0;
    assign nxt_err = 1'b0;
`endif

    // Protection bits carry no meaning here; upper backdoor index bits alias.
    assign unused_sig = ^{S_AXI_ARPROT, size_q, mem_waddr[31:AW]};

    // Backdoor write port; accepted in any state, never reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr[AW-1:0]] <= mem_wdata;
    end

    // Next-state and R-channel output logic.
    always_comb begin
        state_d    = state_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        len_d      = len_q;
        burst_d    = burst_q;
        size_d     = size_q;
        beat_cnt_d = beat_cnt_q;
        arready_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    addr_d     = S_AXI_ARADDR;
                    len_d      = S_AXI_ARLEN;
                    burst_d    = S_AXI_ARBURST;
                    size_d     = S_AXI_ARSIZE;
                    beat_cnt_d = 8'd0;
                    rvalid_d   = 1'b1;
                    rlast_d    = (S_AXI_ARLEN == 8'd0);
                    rdata_d    = ar_err ? 32'h0 : mem_q[word_idx(S_AXI_ARADDR)];
                    rresp_d    = ar_err ? 2'b10 : 2'b00;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (rvalid_q && S_AXI_RREADY) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        addr_d     = nxt_addr;
                        rlast_d    = ((beat_cnt_q + 8'd1) == len_q);
                        rdata_d    = nxt_err ? 32'h0 : mem_q[word_idx(nxt_addr)];
                        rresp_d    = nxt_err ? 2'b10 : 2'b00;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // ARREADY is registered: high exactly while the FSM sits in IDLE.
        arready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= 32'h0;
            addr_q     <= 32'h0;
            len_q      <= 8'd0;
            burst_q    <= 2'b00;
            size_q     <= 3'b000;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            size_q     <= size_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign dbg_burst_o   = (state_q == BURST);

endmodule
